nic_rst_intr_ctrl: RTL and testbench
====================================

Name: nic_rst_intr_ctrl

Overview:
- Multi-channel reset sequencer and interrupt combiner for the NIC wrapper layer.
- Generalises the single-channel reset-stretch and interrupt-synchroniser logic to N_CH NIC cores sharing one PCI function.
- Adds per-channel reset domains, interrupt masking, pending-status reporting, and an INT_N hold-off (moderation) state machine.
- Sits between the NIC cores (reset_request/intr_request sources) and the PCI core INT_N pin.

Parameters:
- N_CH, 1, number of NIC channels (1..8).
- RST_CYCLES, 64, cycles a channel reset is held after its last request (>=1).
- SYNC_STAGES, 2, flop stages on each intr_request input (>=2); intr_request is treated as asynchronous.
- HOLDOFF_CYCLES, 0, minimum cycles INT_N stays high after deasserting before it may reassert; 0 disables hold-off.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  asynchronous, active-high reset.
- clk_locked  in  1  NIC clock generator lock; low forces all channels into reset.
- rst_request  in  N_CH  per-channel synchronous reset request from the NIC core, level.
- intr_request  in  N_CH  per-channel interrupt request, level, asynchronous.
- intr_mask  in  N_CH  1 = channel excluded from INT_N; synchronous.
- aresetn  out  N_CH  per-channel active-low reset to the NIC core and AXI bridges.
- rst_busy  out  1  high while any aresetn bit is low.
- intr_pending  out  N_CH  synchronised, reset-gated interrupt status, ignores mask.
- INT_N  out  1  active-low combined interrupt to the PCI core.

Behaviour:
- Reset values while RST is high:
  - all channel counters = 0
  - aresetn = 0
  - rst_busy = 1
  - sync chains = 0
  - intr_pending = 0
  - state = IDLE
  - INT_N = 1
- Per-channel reset sequencing, counter width $clog2(RST_CYCLES+1):
  - At each edge, if rst_request[i] or !clk_locked: counter cleared to 0 and aresetn[i] cleared to 0. aresetn falls one cycle after the request is sampled.
  - Otherwise, if counter < RST_CYCLES, counter increments. On the edge where it becomes RST_CYCLES, aresetn[i] is set to 1. The counter then saturates.
  - aresetn[i] rises exactly RST_CYCLES edges after the first edge at which the request is sampled low.
  - A request arriving mid-count restarts the count from 0.
  - Channels are independent. clk_locked low affects all channels.
  - rst_busy is registered: rst_busy <= ~&aresetn_next.
- Interrupt path:
  - intr_request[i] passes through a SYNC_STAGES flop chain. The chain flops carry the ASYNC_REG attribute.
  - intr_pending[i] <= sync_out[i] & aresetn[i]. Any channel in reset reports 0.
  - active = |(intr_pending & ~intr_mask).
  - Latency: a rising intr_request reaches intr_pending after SYNC_STAGES+1 edges.
- INT_N state machine (registered output):
  - IDLE (INT_N=1): if active, go to ASSERT. INT_N goes 0 on the same edge.
  - ASSERT (INT_N=0): if !active, go to HOLDOFF and load the hold-off counter with HOLDOFF_CYCLES. If HOLDOFF_CYCLES=0, go directly to IDLE. INT_N goes 1 on that edge.
  - HOLDOFF (INT_N=1): the counter decrements each cycle. On reaching 0, go to IDLE. active is ignored in this state.
  - Masking the last active channel while in ASSERT behaves exactly like deassertion.
  - Unmasking a pending channel while in IDLE asserts on the next edge.
- Boundary cases:
  - A simultaneous rst_request and intr_request on the same channel: reset wins; pending stays 0.
  - Deasserting RST mid-operation: all channels restart the full RST_CYCLES sequence.
  - N_CH=1 with HOLDOFF_CYCLES=0 reproduces legacy behaviour with one extra pipeline stage.

Decomposition:
- Shared package nic_ctrl_pkg holds:
  - INT_N state encodings IDLE=2'd0, ASSERT=2'd1, HOLDOFF=2'd2
  - counter-width helper function
- Sub-module nic_rst_seq holds one channel's reset counter and aresetn flop. It is instantiated N_CH times in a generate loop.
- The interrupt synchroniser and FSM stay in the top module.

Test Plan:
- Reset release: N_CH=2, RST_CYCLES=8, clk_locked=1, no requests; drop RST.
  - Required: aresetn=2'b11 exactly 8 edges later, and rst_busy falls on the same edge.
- Per-channel reset: rst_request[1] pulses 1 cycle at steady state.
  - Required: aresetn[1]=0 on the next edge and returns high 8 edges after the pulse.
  - Required: aresetn[0] stays 1 throughout.
  - A second pulse 4 cycles in restarts the count.
- Lock loss: clk_locked low for 3 cycles.
  - Required: both aresetn bits low the next edge and high 8 edges after clk_locked returns.
  - Required: intr_pending forced to 0 during this period.
- Interrupt latency: SYNC_STAGES=2, intr_request[0] rises, mask=0.
  - Required: intr_pending[0]=1 after 3 edges and INT_N=0 after 4 edges.
  - Required: deassertion returns INT_N to 1 four edges after the input falls.
- Hold-off: HOLDOFF_CYCLES=5, channel 0 toggles 1→0→1 with a 1-cycle gap.
  - Required: INT_N stays high for exactly 5 cycles after deasserting, then reasserts.
- Mask: intr_request=2'b11, mask=2'b01.
  - Required: INT_N=0 and intr_pending=2'b11.
  - Setting mask=2'b11: INT_N goes to 1 on the next edge; intr_pending is unchanged.

Source files
------------

// File: rtl/nic_ctrl_pkg.sv
// Purpose : shared INT_N state encoding and counter sizing helper for the NIC reset/interrupt controller.
// Latency : n/a (types and functions only).
// Backpressure: n/a.
package nic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } int_state_e;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nic_rst_seq.sv
// Purpose : one channel's reset stretcher; holds aresetn low until RST_CYCLES quiet cycles follow the last hold request.
// Latency : aresetn_o falls 1 edge after hold_i is sampled; rises RST_CYCLES edges after hold_i is first sampled low.
// Backpressure: none; hold_i is a level and is obeyed every cycle.
// Ports:
//   clk_i       - clock
//   rst_i       - asynchronous active-high reset (channel held in reset, counter cleared)
//   hold_i      - level request to (re)start the reset sequence
//   aresetn_o   - registered active-low channel reset
//   aresetn_d_o - next-state of aresetn_o, lets the parent register an aggregate busy flag
module nic_rst_seq
  import nic_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  output logic aresetn_o,
  output logic aresetn_d_o
);

  localparam int CW = cnt_width(RST_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(RST_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          aresetn_q, aresetn_d;

  always_comb begin
    cnt_d     = cnt_q;
    aresetn_d = aresetn_q;
    if (hold_i) begin
      cnt_d     = '0;
      aresetn_d = 1'b0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
      // Release on the edge the counter lands on its terminal value; it then saturates.
      if (cnt_d == CNT_MAX) begin
        aresetn_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      aresetn_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      aresetn_q <= aresetn_d;
    end
  end

  assign aresetn_o   = aresetn_q;
  assign aresetn_d_o = aresetn_d;

endmodule

// File: rtl/nic_rst_intr_ctrl.sv
// Purpose : per-channel reset sequencing plus synchronised, maskable interrupt combining onto one INT_N pin.
// Latency : aresetn low 1 edge after request; intr_pending SYNC_STAGES+1 edges after intr_request; INT_N one edge later.
// Backpressure: none; all inputs are levels, INT_N re-assertion is throttled by the hold-off timer only.
// Ports:
//   CLK, RST      - clock, asynchronous active-high reset
//   clk_locked    - NIC clock lock; low holds every channel in reset
//   rst_request   - per-channel synchronous reset request (level)
//   intr_request  - per-channel asynchronous interrupt request (level)
//   intr_mask     - per-channel mask, 1 excludes the channel from INT_N
//   aresetn       - per-channel active-low reset out
//   rst_busy      - high while any channel is in reset
//   intr_pending  - synchronised interrupt status gated by channel reset, mask ignored
//   INT_N         - active-low combined interrupt
module nic_rst_intr_ctrl
  import nic_ctrl_pkg::*;
#(
  parameter int N_CH           = 1,
  parameter int RST_CYCLES     = 64,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clk_locked,
  input  logic [N_CH-1:0] rst_request,
  input  logic [N_CH-1:0] intr_request,
  input  logic [N_CH-1:0] intr_mask,
  output logic [N_CH-1:0] aresetn,
  output logic            rst_busy,
  output logic [N_CH-1:0] intr_pending,
  output logic            INT_N
);

  localparam int HW = cnt_width(HOLDOFF_CYCLES);
  // The IDLE cycle spent before re-asserting is itself one high cycle, so the
  // HOLDOFF state only needs to cover the remaining HOLDOFF_CYCLES-1 cycles.
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 1) ? HW'(HOLDOFF_CYCLES - 1) : '0;

  // ---------------- reset sequencing ----------------
  logic [N_CH-1:0] aresetn_d;
  logic            rst_busy_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nic_rst_seq #(
      .RST_CYCLES (RST_CYCLES)
    ) u_seq (
      .clk_i       (CLK),
      .rst_i       (RST),
      .hold_i      (rst_request[i] | ~clk_locked),
      .aresetn_o   (aresetn[i]),
      .aresetn_d_o (aresetn_d[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_busy_q <= 1'b1;
    end else begin
      rst_busy_q <= ~&aresetn_d;
    end
  end

  // ---------------- interrupt synchroniser ----------------
  (* ASYNC_REG = "TRUE" *) logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] intr_pending_q;
  logic            active;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      intr_pending_q <= '0;
    end else begin
      sync_q[0] <= intr_request;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      // A channel held in reset never reports a pending interrupt.
      intr_pending_q <= sync_q[SYNC_STAGES-1] & aresetn;
    end
  end

  assign active = |(intr_pending_q & ~intr_mask);

  // ---------------- INT_N moderation FSM ----------------
  int_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          int_n_q, int_n_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    int_n_d    = int_n_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = ASSERT;
          int_n_d = 1'b0;
        end
      end
      ASSERT: begin
        if (!active) begin
          int_n_d = 1'b1;
          if (HOLDOFF_CYCLES > 1) begin
            state_d    = HOLDOFF;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        // active is deliberately ignored until the timer expires.
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q <= HW'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        int_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      int_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      int_n_q    <= int_n_d;
    end
  end

  assign rst_busy     = rst_busy_q;
  assign intr_pending = intr_pending_q;
  assign INT_N        = int_n_q;

endmodule

// File: tb/tb_nic_rst_intr_ctrl.sv
// Purpose : self-checking bench for nic_rst_intr_ctrl (2 channels, 8-cycle reset stretch, 2 sync stages, hold-off 5).
// Latency : n/a.
// Backpressure: n/a.
module tb_nic_rst_intr_ctrl;

  localparam int N_CH    = 2;
  localparam int RCYC    = 8;
  localparam int SSTG    = 2;
  localparam int HOLDOFF = 5;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            clk_locked = 1'b1;
  logic [N_CH-1:0] rst_request = '0;
  logic [N_CH-1:0] intr_request = '0;
  logic [N_CH-1:0] intr_mask = '0;
  logic [N_CH-1:0] aresetn;
  logic            rst_busy;
  logic [N_CH-1:0] intr_pending;
  logic            INT_N;

  int checks = 0;
  int passed = 0;

  nic_rst_intr_ctrl #(
    .N_CH           (N_CH),
    .RST_CYCLES     (RCYC),
    .SYNC_STAGES    (SSTG),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .clk_locked   (clk_locked),
    .rst_request  (rst_request),
    .intr_request (intr_request),
    .intr_mask    (intr_mask),
    .aresetn      (aresetn),
    .rst_busy     (rst_busy),
    .intr_pending (intr_pending),
    .INT_N        (INT_N)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Time-stamp view: a channel is out of reset once RCYC edges have passed
  // since the last edge that saw a request (or lock loss); an interrupt is
  // visible two edges after it is sampled; INT_N may fall again only when
  // HOLDOFF cycles have elapsed since it last rose.
  int              cyc = 0;
  int              last_req [N_CH];
  logic [N_CH-1:0] m_aresetn = '0;
  logic [N_CH-1:0] m_pending = '0;
  logic [N_CH-1:0] seen1 = '0, seen2 = '0;
  logic            m_int_n = 1'b1;
  int              m_rise = -1000;
  logic [N_CH-1:0] m_old_ar;
  logic            m_act;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc = 0;
      for (int i = 0; i < N_CH; i++) last_req[i] = 0;
      m_aresetn = '0;
      m_pending = '0;
      seen1 = '0;
      seen2 = '0;
      m_int_n = 1'b1;
      m_rise = -1000;
    end else begin
      m_act    = |(m_pending & ~intr_mask);
      m_old_ar = m_aresetn;
      cyc++;
      for (int i = 0; i < N_CH; i++) begin
        if (rst_request[i] || !clk_locked) last_req[i] = cyc;
        m_aresetn[i] = ((cyc - last_req[i]) >= RCYC);
      end
      m_pending = seen2 & m_old_ar;
      seen2 = seen1;
      seen1 = intr_request;
      if (!m_int_n && !m_act) begin
        m_int_n = 1'b1;
        m_rise  = cyc;
      end else if (m_int_n && m_act && (cyc - m_rise) >= HOLDOFF) begin
        m_int_n = 1'b0;
      end
    end
  end

  logic [6:0] obs_v, exp_v;
  assign obs_v = {aresetn, rst_busy, intr_pending, INT_N};
  assign exp_v = {m_aresetn, ~&m_aresetn, m_pending, m_int_n};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (obs_v !== 7'b00_1_00_1) $display("FAIL reset_values got=%b want=%b", obs_v, 7'b00_1_00_1);
    else passed++;
    RST = 1'b0;
    for (int k = 1; k <= RCYC; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) $display("FAIL reset_release_model k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
      if (k == RCYC - 1) begin
        checks++;
        if (aresetn !== 2'b00 || rst_busy !== 1'b1)
          $display("FAIL reset_release_early got aresetn=%b busy=%b want 00/1", aresetn, rst_busy);
        else passed++;
      end
      if (k == RCYC) begin
        checks++;
        if (aresetn !== 2'b11 || rst_busy !== 1'b0)
          $display("FAIL reset_release_on_time got aresetn=%b busy=%b want 11/0", aresetn, rst_busy);
        else passed++;
      end
    end
  endtask

  task automatic test_chan_reset();
    rst_request = 2'b10;
    @(negedge CLK);
    rst_request = 2'b00;
    checks++;
    if (aresetn !== 2'b01) $display("FAIL chan_reset_fall got=%b want=01", aresetn);
    else passed++;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || aresetn !== {(k >= RCYC), 1'b1})
        $display("FAIL chan_reset_pulse k=%0d got=%b want=%b aresetn_want=%b", k, obs_v, exp_v, {(k >= RCYC), 1'b1});
      else passed++;
    end
    // Second pulse four cycles after the first restarts channel 1's count.
    rst_request = 2'b10;
    @(negedge CLK);
    rst_request = 2'b00;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || aresetn !== {(k >= RCYC + 4), 1'b1})
        $display("FAIL chan_reset_restart k=%0d got=%b want=%b aresetn_want=%b", k, obs_v, exp_v, {(k >= RCYC + 4), 1'b1});
      else passed++;
      rst_request = (k == 3) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_lock_loss();
    intr_mask    = 2'b11;
    intr_request = 2'b11;
    repeat (5) @(negedge CLK);
    checks++;
    if (intr_pending !== 2'b11) $display("FAIL lock_pre_pending got=%b want=11", intr_pending);
    else passed++;
    clk_locked = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || aresetn !== ((k >= RCYC + 2) ? 2'b11 : 2'b00) ||
          (k >= 1 && k <= RCYC + 2 && intr_pending !== 2'b00))
        $display("FAIL lock_loss k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
      if (k == 2) clk_locked = 1'b1;
    end
    intr_request = 2'b00;
    intr_mask    = 2'b00;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_intr_latency();
    intr_request = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || intr_pending[0] !== (k >= SSTG + 1) || INT_N !== (k < SSTG + 2))
        $display("FAIL intr_rise k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
    end
    repeat (3) @(negedge CLK);
    intr_request = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || INT_N !== (k >= 4))
        $display("FAIL intr_fall k=%0d got=%b want=%b INT_N_want=%b", k, obs_v, exp_v, (k >= 4));
      else passed++;
    end
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_holdoff();
    intr_request = 2'b01;
    repeat (6) @(negedge CLK);
    intr_request = 2'b00;
    @(negedge CLK);
    intr_request = 2'b01;
    for (int k = 2; k <= 11; k++) begin
      @(negedge CLK);
      checks++;
      // INT_N rises on the 4th edge after the drop and must stay high for exactly HOLDOFF cycles.
      if (obs_v !== exp_v || INT_N !== (k >= 4 && k < 4 + HOLDOFF))
        $display("FAIL holdoff k=%0d got=%b want=%b INT_N_want=%b", k, obs_v, exp_v, (k >= 4 && k < 4 + HOLDOFF));
      else passed++;
    end
  endtask

  task automatic test_mask();
    intr_request = 2'b11;
    intr_mask    = 2'b01;
    repeat (6) @(negedge CLK);
    checks++;
    if (INT_N !== 1'b0 || intr_pending !== 2'b11)
      $display("FAIL mask_partial got INT_N=%b pending=%b want 0/11", INT_N, intr_pending);
    else passed++;
    intr_mask = 2'b11;
    @(negedge CLK);
    checks++;
    if (INT_N !== 1'b1 || intr_pending !== 2'b11 || obs_v !== exp_v)
      $display("FAIL mask_all got INT_N=%b pending=%b want 1/11", INT_N, intr_pending);
    else passed++;
    repeat (7) @(negedge CLK);
    intr_mask = 2'b10;
    @(negedge CLK);
    checks++;
    if (INT_N !== 1'b0 || obs_v !== exp_v)
      $display("FAIL unmask_assert got INT_N=%b want 0", INT_N);
    else passed++;
    intr_request = 2'b00;
    intr_mask    = 2'b00;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_rst_vs_intr();
    rst_request  = 2'b10;
    intr_request = 2'b10;
    @(negedge CLK);
    rst_request = 2'b00;
    for (int k = 1; k <= RCYC + 1; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || intr_pending[1] !== (k >= RCYC + 1))
        $display("FAIL rst_vs_intr k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
    end
    intr_request = 2'b00;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_rst_midop();
    intr_request = 2'b01;
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (obs_v !== 7'b00_1_00_1) $display("FAIL midop_reset_values got=%b want=%b", obs_v, 7'b00_1_00_1);
    else passed++;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= RCYC; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v || aresetn !== ((k >= RCYC) ? 2'b11 : 2'b00))
        $display("FAIL midop_restart k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
    end
    intr_request = 2'b00;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) $display("FAIL random k=%0d got=%b want=%b", k, obs_v, exp_v);
      else passed++;
      for (int i = 0; i < N_CH; i++) begin
        rst_request[i] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 5) == 0) intr_request[i] = ~intr_request[i];
      end
      clk_locked = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) intr_mask = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_chan_reset();
    test_lock_loss();
    test_intr_latency();
    test_holdoff();
    test_mask();
    test_rst_vs_intr();
    test_rst_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
